// File: rtl/id_to_exe.sv
// ID/EXE pipeline register.
// Captures decoded operands and control from the decode stage. It holds them
// while the pipeline is frozen and loads a bubble when a taken branch
// flushes the stage. A two-state EMPTY/FULL machine tracks whether the stage
// holds a real instruction.
// Optional feature: define ID_TO_EXE_FORWARDING_EN to register src1/src2/isImm
// and forward results from the EXE/MEM and MEM/WB registers onto
// val1/val2/reg2.
module id_to_exe #(
  parameter int WORD_LEN          = 32,
  parameter int EXE_CMD_LEN       = 4,
  parameter int REG_FILE_ADDR_LEN = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         freeze,
  input  logic                         flush,
  input  logic [WORD_LEN-1:0]          PCIn,
  input  logic [WORD_LEN-1:0]          val1In,
  input  logic [WORD_LEN-1:0]          val2In,
  input  logic [WORD_LEN-1:0]          reg2In,
  input  logic [EXE_CMD_LEN-1:0]       EXE_CMD_IN,
  input  logic [REG_FILE_ADDR_LEN-1:0] destIn,
  input  logic [REG_FILE_ADDR_LEN-1:0] src1In,
  input  logic [REG_FILE_ADDR_LEN-1:0] src2In,
  input  logic                         isImmIn,
  input  logic                         MEM_R_EN_IN,
  input  logic                         MEM_W_EN_IN,
  input  logic                         WB_EN_IN,
  input  logic [REG_FILE_ADDR_LEN-1:0] memDest,
  input  logic                         memWbEn,
  input  logic [WORD_LEN-1:0]          memAluResult,
  input  logic [REG_FILE_ADDR_LEN-1:0] wbDest,
  input  logic                         wbWbEn,
  input  logic [WORD_LEN-1:0]          wbValue,
  output logic [WORD_LEN-1:0]          PC,
  output logic [WORD_LEN-1:0]          val1,
  output logic [WORD_LEN-1:0]          val2,
  output logic [WORD_LEN-1:0]          reg2,
  output logic [EXE_CMD_LEN-1:0]       EXE_CMD,
  output logic [REG_FILE_ADDR_LEN-1:0] dest,
  output logic                         MEM_R_EN,
  output logic                         MEM_W_EN,
  output logic                         WB_EN,
  output logic                         valid
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic   load_en;
  logic   clear_en;

  logic [WORD_LEN-1:0]          pc_reg;
  logic [WORD_LEN-1:0]          val1_reg;
  logic [WORD_LEN-1:0]          val2_reg;
  logic [WORD_LEN-1:0]          reg2_reg;
  logic [EXE_CMD_LEN-1:0]       exe_cmd_reg;
  logic [REG_FILE_ADDR_LEN-1:0] dest_reg;
  logic                         mem_r_en_reg;
  logic                         mem_w_en_reg;
  logic                         wb_en_reg;

  // State register; reset always wins and leaves the stage empty.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  // Next state and load/clear strobes: flush beats freeze, freeze beats load.
  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    clear_en   = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      clear_en   = 1'b1;
    end else if (!freeze) begin
      state_next = FULL;
      load_en    = 1'b1;
    end
  end

  // Payload registers: cleared on reset or bubble, captured on load, else held.
  always_ff @(posedge clk) begin
    if (rst || clear_en) begin
      pc_reg       <= '0;
      val1_reg     <= '0;
      val2_reg     <= '0;
      reg2_reg     <= '0;
      exe_cmd_reg  <= '0;
      dest_reg     <= '0;
      mem_r_en_reg <= 1'b0;
      mem_w_en_reg <= 1'b0;
      wb_en_reg    <= 1'b0;
    end else if (load_en) begin
      pc_reg       <= PCIn;
      val1_reg     <= val1In;
      val2_reg     <= val2In;
      reg2_reg     <= reg2In;
      exe_cmd_reg  <= EXE_CMD_IN;
      dest_reg     <= destIn;
      mem_r_en_reg <= MEM_R_EN_IN;
      mem_w_en_reg <= MEM_W_EN_IN;
      wb_en_reg    <= WB_EN_IN;
    end
  end

  assign valid   = (state_reg == FULL);
  assign PC      = pc_reg;
  assign EXE_CMD = exe_cmd_reg;
  assign dest    = dest_reg;
  // Side-effecting enables are gated so an empty stage can never write.
  assign MEM_R_EN = mem_r_en_reg & valid;
  assign MEM_W_EN = mem_w_en_reg & valid;
  assign WB_EN    = wb_en_reg & valid;

`ifdef ID_TO_EXE_FORWARDING_EN
  logic [REG_FILE_ADDR_LEN-1:0] src1_reg;
  logic [REG_FILE_ADDR_LEN-1:0] src2_reg;
  logic                         is_imm_reg;
  logic                         mem_hit1, wb_hit1, mem_hit2, wb_hit2;
  logic [WORD_LEN-1:0]          fwd_src1, fwd_src2;

  // Source registers follow the same reset/flush/freeze rules as the payload.
  always_ff @(posedge clk) begin
    if (rst || clear_en) begin
      src1_reg   <= '0;
      src2_reg   <= '0;
      is_imm_reg <= 1'b0;
    end else if (load_en) begin
      src1_reg   <= src1In;
      src2_reg   <= src2In;
      is_imm_reg <= isImmIn;
    end
  end

  // Bypass selection: register 0 never forwards; the younger MEM result wins.
  always_comb begin
    mem_hit1 = memWbEn && (src1_reg != '0) && (memDest == src1_reg);
    wb_hit1  = wbWbEn  && (src1_reg != '0) && (wbDest  == src1_reg);
    mem_hit2 = memWbEn && (src2_reg != '0) && (memDest == src2_reg);
    wb_hit2  = wbWbEn  && (src2_reg != '0) && (wbDest  == src2_reg);

    fwd_src1 = val1_reg;
    if (mem_hit1)     fwd_src1 = memAluResult;
    else if (wb_hit1) fwd_src1 = wbValue;

    fwd_src2 = reg2_reg;
    if (mem_hit2)     fwd_src2 = memAluResult;
    else if (wb_hit2) fwd_src2 = wbValue;

    val1 = fwd_src1;
    reg2 = fwd_src2;
    // An immediate operand B has no source register to bypass.
    val2 = is_imm_reg ? val2_reg : fwd_src2;
    if (!is_imm_reg && !mem_hit2 && !wb_hit2) val2 = val2_reg;
  end
`else
  // Forwarding inputs stay on the port list so both builds share one wrapper.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{src1In, src2In, isImmIn, memDest, memWbEn,
                               memAluResult, wbDest, wbWbEn, wbValue};

  assign val1 = val1_reg;
  assign val2 = val2_reg;
  assign reg2 = reg2_reg;
`endif

endmodule

// File: tb/tb_id_to_exe.sv
// Scoreboard bench for id_to_exe: the driver applies one directed vector per
// cycle and queues the hand-computed register contents expected after that
// edge; an independent monitor pops and compares one entry per cycle.
module tb_id_to_exe;

`ifdef ID_TO_EXE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [3:0] EXE_ADD = 4'd1;

  typedef struct packed {
    logic rst, freeze, flush;
    logic [31:0] pc, v1, v2, r2;
    logic [3:0]  cmd;
    logic [4:0]  dest, s1, s2;
    logic imm, mr, mw, wb;
    logic [4:0]  md;
    logic        mwe;
    logic [31:0] mv;
    logic [4:0]  wd;
    logic        wwe;
    logic [31:0] wv;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc, v1, v2, r2;
    logic [3:0]  cmd;
    logic [4:0]  dest;
    logic mr, mw, wb, valid;
    logic        chk_alu;
    logic [31:0] alu;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, freeze = 1'b0, flush = 1'b0;
  logic [31:0] PCIn = '0, val1In = '0, val2In = '0, reg2In = '0;
  logic [3:0]  EXE_CMD_IN = '0;
  logic [4:0]  destIn = '0, src1In = '0, src2In = '0;
  logic        isImmIn = 1'b0, MEM_R_EN_IN = 1'b0, MEM_W_EN_IN = 1'b0, WB_EN_IN = 1'b0;
  logic [4:0]  memDest = '0, wbDest = '0;
  logic        memWbEn = 1'b0, wbWbEn = 1'b0;
  logic [31:0] memAluResult = '0, wbValue = '0;
  logic [31:0] PC, val1, val2, reg2;
  logic [3:0]  EXE_CMD;
  logic [4:0]  dest;
  logic        MEM_R_EN, MEM_W_EN, WB_EN, valid;

  id_to_exe dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .PCIn(PCIn), .val1In(val1In), .val2In(val2In), .reg2In(reg2In),
    .EXE_CMD_IN(EXE_CMD_IN), .destIn(destIn), .src1In(src1In), .src2In(src2In),
    .isImmIn(isImmIn), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .WB_EN_IN(WB_EN_IN), .memDest(memDest), .memWbEn(memWbEn),
    .memAluResult(memAluResult), .wbDest(wbDest), .wbWbEn(wbWbEn), .wbValue(wbValue),
    .PC(PC), .val1(val1), .val2(val2), .reg2(reg2), .EXE_CMD(EXE_CMD), .dest(dest),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .valid(valid)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   txn      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL txn %0d %s: got 0x%0h, expected 0x%0h", txn, name, act, req);
  endtask

  // Monitor: one queued expectation per clock, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      check("PC", PC, e.pc);
      check("val1", val1, e.v1);
      check("val2", val2, e.v2);
      check("reg2", reg2, e.r2);
      check("EXE_CMD", {28'd0, EXE_CMD}, {28'd0, e.cmd});
      check("dest", {27'd0, dest}, {27'd0, e.dest});
      check("MEM_R_EN", {31'd0, MEM_R_EN}, {31'd0, e.mr});
      check("MEM_W_EN", {31'd0, MEM_W_EN}, {31'd0, e.mw});
      check("WB_EN", {31'd0, WB_EN}, {31'd0, e.wb});
      check("valid", {31'd0, valid}, {31'd0, e.valid});
      if (e.chk_alu) check("alu_sum", val1 + val2, e.alu);
      $display("txn %0d: PC=%0h val1=%0h val2=%0h reg2=%0h cmd=%0h dest=%0d mr=%0b mw=%0b wb=%0b valid=%0b",
               txn, PC, val1, val2, reg2, EXE_CMD, dest, MEM_R_EN, MEM_W_EN, WB_EN, valid);
    end
  end

  function automatic vec_t vz();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic exp_t ez();
    exp_t e;
    e = '0;
    return e;
  endfunction

  // Expected contents when vector v is loaded with no forwarding effect.
  function automatic exp_t loaded(input vec_t v);
    exp_t e;
    e = '0;
    e.pc = v.pc; e.v1 = v.v1; e.v2 = v.v2; e.r2 = v.r2;
    e.cmd = v.cmd; e.dest = v.dest;
    e.mr = v.mr; e.mw = v.mw; e.wb = v.wb; e.valid = 1'b1;
    return e;
  endfunction

  task automatic run(input vec_t v, input exp_t e);
    @(negedge clk);
    rst = v.rst; freeze = v.freeze; flush = v.flush;
    PCIn = v.pc; val1In = v.v1; val2In = v.v2; reg2In = v.r2;
    EXE_CMD_IN = v.cmd; destIn = v.dest; src1In = v.s1; src2In = v.s2;
    isImmIn = v.imm; MEM_R_EN_IN = v.mr; MEM_W_EN_IN = v.mw; WB_EN_IN = v.wb;
    memDest = v.md; memWbEn = v.mwe; memAluResult = v.mv;
    wbDest = v.wd; wbWbEn = v.wwe; wbValue = v.wv;
    exp_q.push_back(e);
  endtask

  initial begin
    vec_t v;
    exp_t e, held;

    // Reset with every input driven high: everything must read zero.
    v = '1; v.freeze = 1'b0; v.flush = 1'b0;
    run(v, ez());
    // Reset coincident with freeze and flush still wins.
    v = '1;
    run(v, ez());

    // Plain load: 5 + 7 into the ALU, write-back to r3.
    v = vz(); v.pc = 32'h100; v.v1 = 5; v.v2 = 7; v.r2 = 32'hAA;
    v.cmd = EXE_ADD; v.wb = 1'b1; v.dest = 5'd3;
    e = loaded(v); e.chk_alu = 1'b1; e.alu = 32'd12;
    held = e;
    run(v, e);

    // Freeze for three cycles while val1In changes to 9: nothing moves.
    v.freeze = 1'b1; v.v1 = 9;
    for (int i = 0; i < 3; i++) run(v, held);
    // Release: 9 appears one cycle later.
    v.freeze = 1'b0;
    e = held; e.v1 = 9; e.alu = 32'd16;
    run(v, e);

    // Flush and freeze together with a store pending: bubble.
    v = vz(); v.flush = 1'b1; v.freeze = 1'b1; v.mw = 1'b1; v.wb = 1'b1;
    v.cmd = 4'd5; v.pc = 32'h300; v.v1 = 32'h1234; v.dest = 5'd9;
    run(v, ez());
    // Freeze while empty keeps the bubble.
    v.flush = 1'b0;
    run(v, ez());

    // Load a load+store shaped instruction.
    v = vz(); v.pc = 32'h200; v.v1 = 32'h11; v.v2 = 32'h22; v.r2 = 32'h33;
    v.cmd = 4'd2; v.dest = 5'd7; v.mr = 1'b1; v.mw = 1'b1;
    run(v, loaded(v));
    // Reset arriving mid-freeze clears everything.
    v.rst = 1'b1; v.freeze = 1'b1;
    run(v, ez());

    // src1=4 matches both MEM and WB: MEM result wins.
    v = vz(); v.pc = 32'h400; v.v1 = 32'h1; v.v2 = 32'h2; v.r2 = 32'h3;
    v.s1 = 5'd4; v.md = 5'd4; v.mwe = 1'b1; v.mv = 32'h20;
    v.wd = 5'd4; v.wwe = 1'b1; v.wv = 32'h30;
    e = loaded(v); e.v1 = FWD ? 32'h20 : 32'h1;
    run(v, e);
    // Hold registers, drop MEM write enable: WB value takes over.
    v.freeze = 1'b1; v.mwe = 1'b0;
    e.v1 = FWD ? 32'h30 : 32'h1;
    run(v, e);
    // Neither stage writes: registered value.
    v.wwe = 1'b0;
    e.v1 = 32'h1;
    run(v, e);

    // Register 0 never forwards even with matching enabled destinations.
    v = vz(); v.pc = 32'h500; v.v1 = 32'h40; v.v2 = 32'h50; v.r2 = 32'h60;
    v.md = 5'd0; v.mwe = 1'b1; v.mv = 32'hDEAD; v.wd = 5'd0; v.wwe = 1'b1; v.wv = 32'hBEEF;
    run(v, loaded(v));

    // Immediate operand B: val2 untouched, store data forwarded from MEM.
    v = vz(); v.pc = 32'h600; v.v1 = 32'h5; v.v2 = 32'h70; v.r2 = 32'h80;
    v.s2 = 5'd6; v.imm = 1'b1; v.md = 5'd6; v.mwe = 1'b1; v.mv = 32'h99;
    e = loaded(v); e.r2 = FWD ? 32'h99 : 32'h80;
    run(v, e);
    // Register operand B: both val2 and reg2 forwarded, MEM over WB.
    v.imm = 1'b0; v.wd = 5'd6; v.wwe = 1'b1; v.wv = 32'h55;
    e = loaded(v);
    e.v2 = FWD ? 32'h99 : 32'h70; e.r2 = FWD ? 32'h99 : 32'h80;
    run(v, e);
    // Only WB matches.
    v.mwe = 1'b0;
    e.v2 = FWD ? 32'h55 : 32'h70; e.r2 = FWD ? 32'h55 : 32'h80;
    run(v, e);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_to_exe.md
ID_TO_EXE -- requirements
Module: id_to_exe

Interface
REQ-001 The block SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 The block SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 The block SHALL have ports: freeze  in  1  hold all registers (hazard stall); flush  in  1  load a bubble (taken branch).
REQ-004 The block SHALL have ports: PCIn  in  WORD_LEN, val1In/val2In/reg2In  in  WORD_LEN  operand A, operand B (reg or immediate), store data.
REQ-005 The block SHALL have ports: EXE_CMD_IN  in  EXE_CMD_LEN; destIn, src1In, src2In  in  REG_FILE_ADDR_LEN; isImmIn, MEM_R_EN_IN, MEM_W_EN_IN, WB_EN_IN  in  1.
REQ-006 The block SHALL have ports: memDest  in  REG_FILE_ADDR_LEN, memWbEn  in  1, memAluResult  in  WORD_LEN (EXE/MEM register); wbDest, wbWbEn, wbValue, same widths (MEM/WB register).
REQ-007 The block SHALL have ports: PC, val1, val2, reg2  out  WORD_LEN; EXE_CMD  out  EXE_CMD_LEN; dest  out  REG_FILE_ADDR_LEN; MEM_R_EN, MEM_W_EN, WB_EN, valid  out  1.
REQ-008 WORD_LEN, EXE_CMD_LEN, REG_FILE_ADDR_LEN SHALL come from defines.v (32, 4, 5); val1, val2, EXE_CMD drive the ALU directly.

Function
REQ-009 All stage state SHALL be registers updated only on rising clk; per-edge priority rst > flush > freeze > load.
REQ-010 Load (no rst/flush/freeze): every *In value SHALL be captured and valid set to 1; latency exactly one cycle.
REQ-011 Freeze: every register, including valid, SHALL hold its value.
REQ-012 Flush: WB_EN, MEM_R_EN, MEM_W_EN, valid SHALL clear to 0, EXE_CMD to 0, data/address registers to 0; flush SHALL override a simultaneous freeze.
REQ-013 Stage state machine SHALL have two states: EMPTY (valid=0) and FULL (valid=1); load -> FULL, flush/rst -> EMPTY, freeze -> no change.
REQ-014 A bubble (EMPTY) SHALL never assert WB_EN, MEM_R_EN or MEM_W_EN on outputs.
REQ-015 With forwarding disabled, val1, val2, reg2 outputs SHALL equal the registered operand values.
REQ-016 Forwarding match for a source register s SHALL require s != 0 and the matching stage's write enable set.
REQ-017 Forwarded value SHALL be memAluResult if memDest matches, else wbValue if wbDest matches, else the registered value; MEM beats WB when both match.
REQ-018 val1 SHALL be forwarded on src1; reg2 on src2; val2 on src2 only when registered isImm=0.
REQ-019 Forwarding SHALL be combinational from the registered sources and current mem/wb inputs; it SHALL NOT modify stored registers.

Reset
REQ-020 On rst high at a clk edge, all outputs SHALL be 0 (PC, operands, EXE_CMD, dest, enables, valid), state EMPTY.
REQ-021 rst asserted mid-freeze or coincident with flush SHALL still force reset values on that edge.
REQ-022 First load SHALL occur on the first edge with rst low and freeze low.

Configuration
REQ-023 Macro ID_TO_EXE_FORWARDING_EN SHALL, when defined, compile in REQ-016..REQ-019 plus registered src1/src2/isImm.
REQ-024 When undefined, src1In, src2In, isImmIn, mem*/wb* ports SHALL remain present but unused, and REQ-015 applies.

Verification
REQ-025 rst=1 one edge with all inputs 0xFFFFFFFF -> all outputs 0, valid=0.
REQ-026 Load val1In=5, val2In=7, EXE_CMD_IN=EXE_ADD, WB_EN_IN=1, destIn=3 -> next cycle same values, valid=1; ALU output 12.
REQ-027 Freeze=1 for 3 cycles while inputs change to val1In=9 -> outputs stay 5/7/dest 3; release -> 9 appears one cycle later.
REQ-028 Flush=1 and freeze=1 same edge with MEM_W_EN_IN=1 -> MEM_W_EN=0, WB_EN=0, valid=0, EXE_CMD=0.
REQ-029 FORWARDING_EN: src1=4, memDest=4, memWbEn=1, memAluResult=0x20, wbDest=4, wbWbEn=1, wbValue=0x30 -> val1=0x20; memWbEn=0 -> val1=0x30.
REQ-030 FORWARDING_EN: src2=0 with memDest=0, memWbEn=1 -> no forward; src2=6, isImm=1, memDest=6 -> val2 unchanged, reg2=memAluResult.
